// File: rtl/led_driver_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : led_driver_pkg                                                   |
// | Brief    : Shared widths, register map and I2C read-FSM states.             |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
package led_driver_pkg;

  localparam int I2C_ADDR_BITS = 7;
  localparam int ADDR_BITS     = 3;
  localparam int DATA_BITS     = 8;
  localparam int NUM_REGS      = 8;

  localparam logic [ADDR_BITS-1:0] REG_CTRL   = 3'd0;
  localparam logic [ADDR_BITS-1:0] REG_PWM0   = 3'd1;
  localparam logic [ADDR_BITS-1:0] REG_PWM1   = 3'd2;
  localparam logic [ADDR_BITS-1:0] REG_PWM2   = 3'd3;
  localparam logic [ADDR_BITS-1:0] REG_PWM3   = 3'd4;
  localparam logic [ADDR_BITS-1:0] REG_BLINK  = 3'd5;
  localparam logic [ADDR_BITS-1:0] REG_GAIN   = 3'd6;
  localparam logic [ADDR_BITS-1:0] REG_STATUS = 3'd7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    PTR      = 3'd2,
    FETCH    = 3'd3,
    LOAD     = 3'd4,
    WAIT_ACK = 3'd5,
    IGNORE   = 3'd6
  } i2c_rd_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_read_responder_pointer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : i2c_reg_pointer                                                  |
// | Brief    : Register pointer with load and modulo-NUM_REGS advance.          |
// |            Advance only takes effect when I2C_AUTO_INC_EN is defined.       |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module i2c_reg_pointer
  import led_driver_pkg::*;
#(
  parameter int NUM_REGS  = led_driver_pkg::NUM_REGS,
  parameter int ADDR_BITS = led_driver_pkg::ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ADDR_BITS-1:0] load_value,
  input  logic                 advance,
  output logic [ADDR_BITS-1:0] pointer
);

  logic [ADDR_BITS-1:0] r_ptr;

`ifdef I2C_AUTO_INC_EN
  localparam logic [ADDR_BITS:0] c_last_reg = (ADDR_BITS+1)'(NUM_REGS - 1);
  logic [ADDR_BITS-1:0] w_ptr_inc;

  // Any pointer at or beyond the last register wraps back to 0.
  assign w_ptr_inc = ({1'b0, r_ptr} >= c_last_reg) ? '0 : r_ptr + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        r_ptr <= '0;
    else if (load)    r_ptr <= load_value;
    else if (advance) r_ptr <= w_ptr_inc;
  end
`else
  logic w_unused_advance;
  assign w_unused_advance = advance;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     r_ptr <= '0;
    else if (load) r_ptr <= load_value;
  end
`endif

  assign pointer = r_ptr;

endmodule
`default_nettype wire

// File: rtl/i2c_read_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : i2c_read_responder                                               |
// | Brief    : I2C read-direction responder: pointer tracking, register fetch   |
// |            and byte hand-off to the PHY. Auto-increment: I2C_AUTO_INC_EN.   |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module i2c_read_responder
  import led_driver_pkg::*;
#(
  parameter logic [I2C_ADDR_BITS-1:0] DEVICE_ADDR = 7'h40,
  parameter int                       NUM_REGS    = led_driver_pkg::NUM_REGS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sleep,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 rx_valid,
  input  logic [7:0]           rx_data,
  input  logic                 ack_valid,
  input  logic                 ack_n,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [DATA_BITS-1:0] rd_data,
  output logic                 tx_valid,
  output logic [7:0]           tx_data,
  output logic                 addr_match,
  output logic                 busy
);

  localparam logic [ADDR_BITS:0] c_num_regs = (ADDR_BITS+1)'(NUM_REGS);

  i2c_rd_state_t        r_state, w_next;
  logic                 r_addr_match;
  logic [7:0]           r_tx_data;
  logic                 w_match, w_ptr_load, w_ptr_adv, w_load_tx;
  logic                 w_addr_hit, w_in_range;
  logic [ADDR_BITS-1:0] w_ptr;

  i2c_reg_pointer #(
    .NUM_REGS  (NUM_REGS),
    .ADDR_BITS (ADDR_BITS)
  ) u_pointer (
    .clk        (clk),
    .reset      (reset),
    .load       (w_ptr_load),
    .load_value (rx_data[ADDR_BITS-1:0]),
    .advance    (w_ptr_adv),
    .pointer    (w_ptr)
  );

  assign w_addr_hit = (rx_data[7:1] == DEVICE_ADDR);
  assign w_in_range = ({1'b0, w_ptr} < c_num_regs);

  always_comb begin
    w_next     = r_state;
    w_match    = 1'b0;
    w_ptr_load = 1'b0;
    w_ptr_adv  = 1'b0;
    if (sleep || stop) begin
      w_next = IDLE;
    end else if (start) begin
      w_next = ADDR;
    end else begin
      case (r_state)
        ADDR: if (rx_valid) begin
          if (w_addr_hit) begin
            w_match = 1'b1;
            w_next  = rx_data[0] ? FETCH : PTR;
          end else begin
            w_next = IGNORE;
          end
        end
        PTR: if (rx_valid) begin
          w_ptr_load = 1'b1;
          w_next     = IGNORE;
        end
        FETCH:    w_next = LOAD;
        LOAD:     w_next = WAIT_ACK;
        WAIT_ACK: if (ack_valid) begin
          w_ptr_adv = ~ack_n;
          w_next    = ack_n ? IGNORE : FETCH;
        end
        default:  w_next = r_state;
      endcase
    end
  end

  assign w_load_tx = (r_state == LOAD) && (w_next == WAIT_ACK);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_addr_match <= 1'b0;
      r_tx_data    <= '0;
    end else begin
      r_state      <= w_next;
      r_addr_match <= w_match;
      if (w_load_tx) r_tx_data <= w_in_range ? rd_data : 8'h00;
    end
  end

  // Sleep masks the strobes in the same cycle it rises, before IDLE is reached.
  assign rd_en      = (r_state == FETCH) && w_in_range && !sleep;
  assign rd_addr    = w_ptr;
  assign tx_valid   = (r_state == WAIT_ACK) && !sleep;
  assign tx_data    = r_tx_data;
  assign addr_match = r_addr_match;
  assign busy       = (r_state != IDLE) && !sleep;

endmodule
`default_nettype wire

// File: tb/tb_i2c_read_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_i2c_read_responder                                            |
// | Brief    : Directed bench with a timeline model of the read responder.      |
// | Revision : 1.0                                                              |
// +-----------------------------------------------------------------------------+
module tb_i2c_read_responder;

  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       reset, sleep, start, stop, rx_valid, ack_valid, ack_n;
  logic [7:0] rx_data;
  logic       rd_en, tx_valid, addr_match, busy;
  logic [2:0] rd_addr;
  logic [7:0] rd_data, tx_data;
  logic       rd_en_b, tx_valid_b, addr_match_b, busy_b;
  logic [2:0] rd_addr_b;
  logic [7:0] rd_data_b, tx_data_b;

  logic [7:0] regs [8];
  int         cyc = 0;

  bit         exp_rd_en [MAXC];
  bit [2:0]   exp_rd_addr [MAXC];
  bit         exp_match [MAXC];
  bit         exp_busy [MAXC];
  bit         exp_txv [MAXC];
  bit [7:0]   exp_txd [MAXC];

  int         vectors = 0, miscompares = 0;
  int         n_rd = 0, n_match = 0, n_rd_b = 0;
  int         m_ptr = 0;
  logic [7:0] got [$];
  logic       b_txv;
  logic [7:0] b_txd;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (rd_en)   rd_data   <= regs[rd_addr];
  always @(posedge clk) if (rd_en_b) rd_data_b <= regs[rd_addr_b];

  i2c_read_responder dut (
    .clk(clk), .reset(reset), .sleep(sleep), .start(start), .stop(stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .ack_valid(ack_valid), .ack_n(ack_n),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .tx_valid(tx_valid),
    .tx_data(tx_data), .addr_match(addr_match), .busy(busy)
  );

  i2c_read_responder #(.NUM_REGS(6)) dut_b (
    .clk(clk), .reset(reset), .sleep(sleep), .start(start), .stop(stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .ack_valid(ack_valid), .ack_n(ack_n),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .tx_valid(tx_valid_b),
    .tx_data(tx_data_b), .addr_match(addr_match_b), .busy(busy_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_cycle();
    int c;
    c = cyc;
    if (!reset && c < MAXC) begin
      chk("rd_en", 32'(rd_en), 32'(exp_rd_en[c]));
      chk("addr_match", 32'(addr_match), 32'(exp_match[c]));
      chk("busy", 32'(busy), 32'(exp_busy[c]));
      chk("tx_valid", 32'(tx_valid), 32'(exp_txv[c]));
      if (exp_rd_en[c]) chk("rd_addr", 32'(rd_addr), 32'(exp_rd_addr[c]));
      if (exp_txv[c])   chk("tx_data", 32'(tx_data), 32'(exp_txd[c]));
      if (rd_en)      n_rd++;
      if (addr_match) n_match++;
      if (rd_en_b)    n_rd_b++;
    end
  endtask

  task automatic step();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
    start = 1'b0; stop = 1'b0; rx_valid = 1'b0; ack_valid = 1'b0;
  endtask

  task automatic set_busy(input int c, input bit v);
    for (int i = c; i < MAXC; i++) exp_busy[i] = v;
  endtask
  task automatic set_txv(input int c, input bit v);
    for (int i = c; i < MAXC; i++) exp_txv[i] = v;
  endtask
  task automatic set_txd(input int c, input bit [7:0] v);
    for (int i = c; i < MAXC; i++) exp_txd[i] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1; set_busy(cyc + 1, 1'b1); set_txv(cyc + 1, 1'b0); step();
  endtask
  task automatic pulse_stop();
    stop = 1'b1; set_busy(cyc + 1, 1'b0); set_txv(cyc + 1, 1'b0); step();
  endtask

  task automatic send_addr(input logic [7:0] b, input bit hit);
    rx_valid = 1'b1; rx_data = b;
    if (hit) exp_match[cyc + 1] = 1'b1;
    step();
  endtask

  task automatic write_ptr(input logic [7:0] p);
    pulse_start();
    send_addr(8'h80, 1'b1);
    rx_valid = 1'b1; rx_data = p; step();
    m_ptr = p % 8;
    rx_valid = 1'b1; rx_data = 8'h5C; step();
    pulse_stop();
  endtask

  // mode 0: NACK last byte then STOP; 1: STOP in last WAIT_ACK;
  // 2: START+STOP in last WAIT_ACK; 3: sleep in last WAIT_ACK.
  task automatic read_burst(input int nbytes, input int mode, input bit noise);
    int f, m;
    bit nack;
    got.delete();
    pulse_start();
    send_addr(8'h81, 1'b1);
    f = cyc;
    m = cyc;
    for (int k = 0; k < nbytes; k++) begin
      exp_rd_en[f] = 1'b1; exp_rd_addr[f] = 3'(m_ptr);
      set_txv(f + 2, 1'b1); set_txd(f + 2, regs[m_ptr]);
      if (noise) begin ack_valid = 1'b1; ack_n = 1'b0; end
      step();
      if (noise) begin rx_valid = 1'b1; rx_data = 8'h81; end
      step();
      got.push_back(tx_data); b_txv = tx_valid_b; b_txd = tx_data_b;
      if (noise) begin rx_valid = 1'b1; rx_data = 8'h80; end
      step();
      m = cyc;
      if (k < nbytes - 1 || mode == 0) begin
        nack = (k == nbytes - 1);
        ack_valid = 1'b1; ack_n = nack;
        set_txv(m + 1, 1'b0);
        step();
        if (!nack) begin
`ifdef I2C_AUTO_INC_EN
          m_ptr = (m_ptr + 1) % 8;
`endif
          f = m + 1;
        end
      end
    end
    case (mode)
      0: begin step(); step(); pulse_stop(); end
      1, 2: begin
        stop = 1'b1; start = (mode == 2);
        set_busy(m + 1, 1'b0); set_txv(m + 1, 1'b0);
        step();
        chk(mode == 1 ? "stop_txv" : "startstop_txv", 32'(tx_valid), 32'd0);
        chk(mode == 1 ? "stop_busy" : "startstop_busy", 32'(busy), 32'd0);
      end
      default: begin
        sleep = 1'b1; set_busy(m, 1'b0); set_txv(m, 1'b0);
        #1;
        chk("sleep_busy", 32'(busy), 32'd0);
        chk("sleep_txv", 32'(tx_valid), 32'd0);
        start = 1'b1; step(); step();
        sleep = 1'b0; step();
      end
    endcase
  endtask

  initial begin
    int r0, rb0, mt0, f;
    regs[0] = 8'h99; regs[1] = 8'hAA; regs[2] = 8'h22; regs[3] = 8'h33;
    regs[4] = 8'h44; regs[5] = 8'h5A; regs[6] = 8'h11; regs[7] = 8'h55;
    reset = 1'b1; sleep = 1'b0; start = 1'b0; stop = 1'b0;
    rx_valid = 1'b0; rx_data = 8'h00; ack_valid = 1'b0; ack_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_rd_en", 32'(rd_en), 32'd0);
    chk("reset_rd_addr", 32'(rd_addr), 32'd0);
    chk("reset_tx_valid", 32'(tx_valid), 32'd0);
    chk("reset_tx_data", 32'(tx_data), 32'd0);
    chk("reset_addr_match", 32'(addr_match), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    step(); step();
    reset = 1'b0;
    step();

    // Set pointer to REG_PWM0, then a single NACKed read.
    write_ptr(8'h01);
    r0 = n_rd;
    read_burst(1, 0, 1'b0);
    chk("read1_data", 32'(got[0]), 32'hAA);
    chk("read1_rd_en_count", 32'(n_rd - r0), 32'd1);
    chk("read1_busy_after_stop", 32'(busy), 32'd0);

    // Pointer 7: in range for 8 registers, out of range for 6.
    write_ptr(8'h07);
    rb0 = n_rd_b;
    read_burst(1, 0, 1'b0);
    chk("ptr7_data", 32'(got[0]), 32'h55);
    chk("oor_rd_en_count", 32'(n_rd_b - rb0), 32'd0);
    chk("oor_tx_valid", 32'(b_txv), 32'd1);
    chk("oor_tx_data", 32'(b_txd), 32'h00);

    // Burst with wrap, plus stray ACK/bytes outside their states.
    write_ptr(8'h06);
    read_burst(3, 0, 1'b1);
    chk("burst_b0", 32'(got[0]), 32'h11);
`ifdef I2C_AUTO_INC_EN
    chk("burst_b1", 32'(got[1]), 32'h55);
    chk("burst_b2", 32'(got[2]), 32'h99);
`else
    chk("burst_b1", 32'(got[1]), 32'h11);
    chk("burst_b2", 32'(got[2]), 32'h11);
`endif

    // Foreign address: nothing happens until STOP.
    r0 = n_rd; mt0 = n_match;
    pulse_start();
    send_addr(8'h83, 1'b0);
    rx_valid = 1'b1; rx_data = 8'h01; step();
    step();
    pulse_stop();
    chk("wrong_addr_match_count", 32'(n_match - mt0), 32'd0);
    chk("wrong_addr_rd_en_count", 32'(n_rd - r0), 32'd0);

    // 0x0A loads low bits = 2; then STOP and START+STOP inside WAIT_ACK.
    write_ptr(8'h0A);
    read_burst(1, 1, 1'b0);
    chk("ptr0a_data", 32'(got[0]), 32'h22);
    read_burst(1, 2, 1'b0);
    chk("after_stop_data", 32'(got[0]), 32'h22);

    // Sleep mid-burst, then resume from the retained pointer.
    write_ptr(8'h03);
    read_burst(2, 3, 1'b0);
    chk("sleep_b0", 32'(got[0]), 32'h33);
    read_burst(1, 0, 1'b0);
`ifdef I2C_AUTO_INC_EN
    chk("resume_data", 32'(got[0]), 32'h44);
`else
    chk("resume_data", 32'(got[0]), 32'h33);
`endif

    // Asynchronous reset while rd_en is high.
    write_ptr(8'h05);
    pulse_start();
    send_addr(8'h81, 1'b1);
    f = cyc;
    exp_rd_en[f] = 1'b1; exp_rd_addr[f] = 3'(m_ptr);
    #1 reset = 1'b1;
    #1;
    chk("areset_rd_en", 32'(rd_en), 32'd0);
    chk("areset_tx_valid", 32'(tx_valid), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_tx_data", 32'(tx_data), 32'd0);
    chk("areset_rd_addr", 32'(rd_addr), 32'd0);
    for (int i = f; i < MAXC; i++) begin exp_rd_en[i] = 1'b0; exp_match[i] = 1'b0; end
    set_busy(f, 1'b0); set_txv(f, 1'b0);
    m_ptr = 0;
    step();
    reset = 1'b0;
    step(); step();
    read_burst(1, 0, 1'b0);
    chk("post_reset_data", 32'(got[0]), 32'h99);
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/i2c_read_responder.md
# i2c_read_responder

Read-direction companion to `i2c_controller` on the LED driver's I2C slave port. It tracks the register pointer set by a write-addressed transfer. On an addressed read it fetches registers from the register file and hands bytes to the I2C PHY for shifting out. It advances the pointer on each master ACK and releases on NACK, STOP or sleep.

## Interface
Parameters:
- `DEVICE_ADDR`, default 7'h40: 7-bit slave address; must match `i2c_controller`.
- `NUM_REGS`, default 8 (from `led_driver_pkg`): number of readable registers; the pointer wraps at this value.

Ports:
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: reset is asynchronous and active-high.
- `sleep` input, 1 bit: global sleep.
- `start` input, 1 bit: START or repeated START pulse from the PHY.
- `stop` input, 1 bit: STOP pulse from the PHY.
- `rx_valid` input, 1 bit: received byte valid (1-cycle pulse).
- `rx_data` input, 8 bits: received byte.
- `ack_valid` input, 1 bit: master ACK bit sampled after a transmitted byte (pulse).
- `ack_n` input, 1 bit: 0 means ACK, 1 means NACK; qualified by `ack_valid`.
- `rd_en` output, 1 bit: register-file read strobe.
- `rd_addr` output, `ADDR_BITS` wide: register-file read address.
- `rd_data` input, `DATA_BITS` wide: register-file read data, valid one cycle after `rd_en`.
- `tx_valid` output, 1 bit: `tx_data` is loaded and stable for the PHY.
- `tx_data` output, 8 bits: byte to transmit.
- `addr_match` output, 1 bit: 1-cycle pulse when the address byte matches `DEVICE_ADDR`, for the PHY's address ACK.
- `busy` output, 1 bit: high in every state except `IDLE`.

## Operation
- States are `IDLE`, `ADDR`, `PTR`, `FETCH`, `LOAD`, `WAIT_ACK` and `IGNORE`.
- `IDLE` to `ADDR`: on `start`.
- `ADDR`, on `rx_valid`:
  - `rx_data[7:1]==DEVICE_ADDR` with R/W=0: pulse `addr_match`, go to `PTR`.
  - Match with R/W=1: pulse `addr_match`, go to `FETCH`.
  - No match: go to `IGNORE`.
- `PTR`: the next `rx_valid` loads the pointer with `rx_data[ADDR_BITS-1:0]`, then go to `IGNORE`. Later data bytes belong to `i2c_controller`.
- `FETCH`: one cycle. `rd_en`=1, `rd_addr`=pointer. Next state is `LOAD`.
- `LOAD`: capture `rd_data` into `tx_data`, set `tx_valid`, go to `WAIT_ACK`.
- `WAIT_ACK`: hold `tx_data` and `tx_valid` until `ack_valid`, then clear `tx_valid`.
  - `ack_n`=0: advance the pointer, go to `FETCH`.
  - `ack_n`=1: go to `IGNORE`.
- `IGNORE`: `start` goes to `ADDR`; `stop` goes to `IDLE`.
- From any state, `start` goes to `ADDR` and `stop` goes to `IDLE`, with `tx_valid` cleared. If both are high in the same cycle, `stop` wins.
- Pointer out of range (>= `NUM_REGS`): `rd_en` stays low and `tx_data`=8'h00.
- Pointer advance is modulo `NUM_REGS`: `NUM_REGS-1` wraps to 0.
- The pointer persists across transactions. Only `reset` clears it.
- `sleep` high: force `IDLE` and ignore all inputs. Pointer is retained; `tx_valid`, `rd_en` and `busy` are 0.
- Reset values: every output is 0, the pointer is 0, the state is `IDLE`. An asynchronous reset during a read aborts it with no further `rd_en` pulse.

## Timing
- Address+R byte arrives with `rx_valid` in cycle N:
  - `rd_en` high in cycle N+1.
  - `rd_data` sampled at the end of N+2.
  - `tx_valid` and `tx_data` valid from N+3.
- `ack_valid`(ACK) in cycle M: `tx_valid`=0 in M+1, `rd_en` in M+1, next byte valid from M+3.
- `rd_en` is exactly one cycle wide per byte.
- `addr_match` is registered and high only in cycle N+1.
- `ack_valid` outside `WAIT_ACK` is ignored. `rx_valid` in `FETCH`, `LOAD` or `WAIT_ACK` is ignored.

## Configuration
- `I2C_AUTO_INC_EN` defined: pointer advances on each master ACK, as in Operation.
- `I2C_AUTO_INC_EN` undefined: the pointer does not change on ACK, so every byte of a burst re-reads the same register. Address matching and the `FETCH`/`LOAD` timing are unchanged.

## Structure
- `led_driver_pkg` gains:
  - `i2c_rd_state_t`, the enum of the seven states.
  - `NUM_REGS`.
  - It already carries `I2C_ADDR_BITS`, `ADDR_BITS`, `DATA_BITS` and the `REG_*` constants.
- Sub-module `i2c_reg_pointer`: holds the pointer, with load, advance and modulo-`NUM_REGS` wrap. Advance is gated by `I2C_AUTO_INC_EN`.
- The read FSM stays in the top module.

## Test plan
- Write pointer then read, with register file model REG_PWM0 (0x01)=0xAA: START, 0x80, 0x01, STOP, then START, 0x81, NACK → one `rd_en` with `rd_addr`=1, `tx_data`=0xAA, back to `IDLE` after STOP.
- Burst with wrap: pointer=6, REG 6=0x11, 7=0x55, 0=0x99; read with ACK, ACK, NACK → `tx_data` 0x11, 0x55, 0x99 in order. With auto-increment compiled out: 0x11, 0x11, 0x11.
- Wrong address 0x83 → no `addr_match`, no `rd_en`, `tx_valid` stays 0 until STOP.
- Out-of-range pointer 0x0A (with `NUM_REGS`=8 the low 3 bits give 2, so the load is in range). Test true out-of-range with `NUM_REGS`=6 and pointer 7 → `rd_en` stays 0, `tx_data`=8'h00.
- STOP asserted in `WAIT_ACK` → `tx_valid`=0 next cycle, `IDLE`. START and STOP asserted together → `IDLE`.
- `sleep` mid-burst, then deassert and read again → resumes from the retained pointer. `reset` mid-read → all outputs 0 immediately and pointer=0.
